// File: rtl/digital_up_converter.sv
// Transmit upconverter: linear x INTERP interpolation of baseband I/Q,
// then mixing onto an fs/4 carrier to give one real sample per clock.
module digital_up_converter #(
  parameter int DATA_W = 16,
  parameter int INTERP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear_underflow,
  output logic [DATA_W-1:0] output_data,
  output logic              output_valid,
  output logic              underflow
);

  localparam int LOG2_I = $clog2(INTERP);
  localparam int PW     = DATA_W + 2 + LOG2_I;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic signed [DATA_W-1:0] SMIN =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] SMAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [LOG2_I-1:0] KLAST = LOG2_I'(INTERP - 1);

  logic [0:0]               state;
  logic signed [DATA_W-1:0] prev_i, prev_q;
  logic signed [DATA_W-1:0] cur_i, cur_q;
  logic [LOG2_I-1:0]        k;
  logic [1:0]               p;

  logic                     last;
  logic                     accept;
  logic signed [DATA_W-1:0] int_i, int_q;
  logic signed [DATA_W-1:0] mix;

  function automatic logic signed [DATA_W-1:0] lerp(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [LOG2_I-1:0]        kk
  );
    logic signed [PW-1:0] d, m, s;
    d = PW'(b) - PW'(a);
    m = d * $signed({{(PW-LOG2_I){1'b0}}, kk});
    s = (m >>> LOG2_I) + PW'(a);
    return s[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] neg_sat(
    input logic signed [DATA_W-1:0] x
  );
    return (x == SMIN) ? SMAX : -x;
  endfunction

  assign last     = (state == RUN) && (k == KLAST);
  assign in_ready = (state == IDLE) || last;
  assign accept   = in_valid && in_ready;

  assign int_i = lerp(prev_i, cur_i, k);
  assign int_q = lerp(prev_q, cur_q, k);

  // out = I*cos - Q*sin with the carrier at fs/4
  always_comb begin
    mix = int_i;
    unique case (p)
      2'd0: mix = int_i;
      2'd1: mix = neg_sat(int_q);
      2'd2: mix = neg_sat(int_i);
      2'd3: mix = int_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      prev_i <= '0;
      prev_q <= '0;
      cur_i  <= '0;
      cur_q  <= '0;
      k      <= '0;
    end else if (accept) begin
      prev_i <= cur_i;
      prev_q <= cur_q;
      cur_i  <= in_i;
      cur_q  <= in_q;
      k      <= '0;
      state  <= RUN;
    end else if (last) begin
      // starved: drop to idle so the next burst ramps from zero
      state  <= IDLE;
      prev_i <= '0;
      prev_q <= '0;
      cur_i  <= '0;
      cur_q  <= '0;
    end else if (state == RUN) begin
      k <= k + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (last && !accept) begin
      underflow <= 1'b1;
    end else if (clear_underflow) begin
      underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      output_data  <= '0;
      output_valid <= 1'b0;
      p            <= 2'd0;
    end else if (state == RUN) begin
      output_data  <= mix;
      output_valid <= 1'b1;
      p            <= p + 2'd1;
    end else begin
      output_valid <= 1'b0;
      p            <= 2'd0;
    end
  end

endmodule
